// File: rtl/exec_unit_mc_if.sv
// Issue, data-memory and result channels of the multi-cycle execution unit.
interface exec_unit_mc_if #(
  parameter int REG_LEN       = 4,
  parameter int MEMI_SIZE_LOG = 4,
  parameter int MEMD_SIZE_LOG = 2,
  parameter int INST_SIZE_LOG = 2,
  parameter int TAG_W         = 2
);
  logic                     flush;
  logic                     in_valid;
  logic                     in_ready;
  logic [MEMI_SIZE_LOG-1:0] in_pc;
  logic [INST_SIZE_LOG-1:0] in_op;
  logic [REG_LEN-1:0]       in_imm;
  logic [MEMI_SIZE_LOG-1:0] in_br_offset;
  logic [REG_LEN-1:0]       in_rs1_data;
  logic [REG_LEN-1:0]       in_rs2_data;
  logic                     in_use_alu;
  logic                     in_is_br;
  logic [TAG_W-1:0]         in_tag;
  logic                     mem_req_valid;
  logic                     mem_req_ready;
  logic [MEMD_SIZE_LOG-1:0] mem_req_addr;
  logic                     mem_resp_valid;
  logic [REG_LEN-1:0]       mem_resp_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [REG_LEN-1:0]       out_rd_data;
  logic                     out_taken;
  logic [MEMI_SIZE_LOG-1:0] out_next_pc;
  logic [TAG_W-1:0]         out_tag;

  modport master (
    output flush, in_valid, in_pc, in_op, in_imm, in_br_offset, in_rs1_data,
           in_rs2_data, in_use_alu, in_is_br, in_tag, mem_req_ready,
           mem_resp_valid, mem_resp_data, out_ready,
    input  in_ready, mem_req_valid, mem_req_addr, out_valid, out_rd_data,
           out_taken, out_next_pc, out_tag
  );

  modport slave (
    input  flush, in_valid, in_pc, in_op, in_imm, in_br_offset, in_rs1_data,
           in_rs2_data, in_use_alu, in_is_br, in_tag, mem_req_ready,
           mem_resp_valid, mem_resp_data, out_ready,
    output in_ready, mem_req_valid, mem_req_addr, out_valid, out_rd_data,
           out_taken, out_next_pc, out_tag
  );
endinterface

// File: rtl/exec_unit_mc.sv
// Multi-cycle execution unit: LI/ADD single cycle, shift-add MUL, one-outstanding load.
// state    | meaning
// IDLE     | ready for a new op
// MUL      | one multiplier bit per cycle, REG_LEN cycles
// MEM_REQ  | load request presented
// MEM_WAIT | waiting for load response
// DRAIN    | flushed load, swallow its response
// DONE     | result held until consumed
module exec_unit_mc #(
  parameter int REG_LEN       = 4,
  parameter int MEMI_SIZE_LOG = 4,
  parameter int MEMD_SIZE_LOG = 2,
  parameter int INST_SIZE_LOG = 2,
  parameter int TAG_W         = 2
) (
  input logic           clk,
  input logic           rst,
  exec_unit_mc_if.slave bus
);
  localparam logic [INST_SIZE_LOG-1:0] OP_LI  = INST_SIZE_LOG'(0);
  localparam logic [INST_SIZE_LOG-1:0] OP_ADD = INST_SIZE_LOG'(1);
  localparam logic [INST_SIZE_LOG-1:0] OP_MUL = INST_SIZE_LOG'(2);
  localparam int CNT_W = (REG_LEN > 1) ? $clog2(REG_LEN) : 1;

  typedef enum logic [2:0] {IDLE, MUL, MEM_REQ, MEM_WAIT, DRAIN, DONE} state_t;

  state_t                   state;
  logic [REG_LEN-1:0]       mcand;
  logic [REG_LEN-1:0]       mplier;
  logic [CNT_W-1:0]         cnt;
  logic [REG_LEN-1:0]       alu_res;
  logic                     taken_c;
  logic [MEMI_SIZE_LOG-1:0] next_pc_c;

  always_comb begin
    alu_res = '0;
    case (bus.in_op)
      OP_LI:   alu_res = bus.in_imm;
      OP_ADD:  alu_res = bus.in_rs1_data + bus.in_rs2_data;
      default: alu_res = '0;
    endcase
    taken_c   = (bus.in_rs2_data == '0);
    next_pc_c = (bus.in_is_br && taken_c) ? bus.in_pc + bus.in_br_offset
                                          : bus.in_pc + MEMI_SIZE_LOG'(1);
  end

  assign bus.in_ready = (state == IDLE) & ~bus.flush & ~rst;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= IDLE;
      mcand             <= '0;
      mplier            <= '0;
      cnt               <= '0;
      bus.out_valid     <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.out_rd_data   <= '0;
      bus.out_taken     <= 1'b0;
      bus.out_next_pc   <= '0;
      bus.out_tag       <= '0;
    end else if (bus.flush) begin
      // a response arriving with the flush counts as the drained one
      state             <= (state == MEM_WAIT && !bus.mem_resp_valid) ? DRAIN : IDLE;
      bus.out_valid     <= 1'b0;
      bus.mem_req_valid <= 1'b0;
      cnt               <= '0;
    end else begin
      case (state)
        IDLE: if (bus.in_valid && bus.in_ready) begin
          mcand           <= bus.in_rs1_data;
          mplier          <= bus.in_rs2_data;
          bus.out_taken   <= taken_c;
          bus.out_next_pc <= next_pc_c;
          bus.out_tag     <= bus.in_tag;
          if (!bus.in_use_alu) begin
            state             <= MEM_REQ;
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_addr  <= bus.in_rs1_data[MEMD_SIZE_LOG-1:0];
          end else if (bus.in_op == OP_MUL) begin
            state           <= MUL;
            bus.out_rd_data <= '0;
            cnt             <= CNT_W'(REG_LEN - 1);
          end else begin
            state           <= DONE;
            bus.out_rd_data <= alu_res;
            bus.out_valid   <= 1'b1;
          end
        end
        MUL: begin
          if (mplier[0]) bus.out_rd_data <= bus.out_rd_data + mcand;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CNT_W'(1);
          if (cnt == '0) begin
            state         <= DONE;
            bus.out_valid <= 1'b1;
          end
        end
        MEM_REQ: if (bus.mem_req_ready) begin
          bus.mem_req_valid <= 1'b0;
          state             <= MEM_WAIT;
        end
        MEM_WAIT: if (bus.mem_resp_valid) begin
          bus.out_rd_data <= bus.mem_resp_data;
          bus.out_valid   <= 1'b1;
          state           <= DONE;
        end
        DRAIN: if (bus.mem_resp_valid) state <= IDLE;
        DONE: if (bus.out_ready) begin
          bus.out_valid <= 1'b0;
          state         <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_exec_unit_mc.sv
// Directed bench for exec_unit_mc: transaction-level model checked every cycle plus literal expectations.
module tb_exec_unit_mc;
  localparam int REG_LEN = 4, MEMI = 4, MEMD = 2, INSTW = 2, TAGW = 2;
  localparam logic [1:0] OP_LI = 2'd0, OP_ADD = 2'd1, OP_MUL = 2'd2, OP_UND = 2'd3;

  typedef struct {
    logic [1:0] op; logic [3:0] imm; logic [3:0] rs1; logic [3:0] rs2;
    logic [3:0] pc; logic [3:0] off; logic is_br; logic [1:0] tag;
    int rd; int taken; int npc; int lat;
  } vec_t;
  typedef struct { int rd; int taken; int npc; int tag; } res_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int total = 0;
  int bad = 0;
  vec_t vecs[8];

  exec_unit_mc_if #(.REG_LEN(REG_LEN), .MEMI_SIZE_LOG(MEMI), .MEMD_SIZE_LOG(MEMD),
                    .INST_SIZE_LOG(INSTW), .TAG_W(TAGW)) bus ();
  exec_unit_mc #(.REG_LEN(REG_LEN), .MEMI_SIZE_LOG(MEMI), .MEMD_SIZE_LOG(MEMD),
                 .INST_SIZE_LOG(INSTW), .TAG_W(TAGW)) dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Architectural result of one op, from plain arithmetic.
  function automatic res_t model_op(input logic [1:0] op, input logic [3:0] imm,
                                    input logic [3:0] rs1, input logic [3:0] rs2,
                                    input logic [3:0] pc, input logic [3:0] off,
                                    input logic is_br, input logic [1:0] tag);
    res_t r;
    int v;
    int np;
    case (op)
      OP_LI:   v = int'(imm);
      OP_ADD:  v = int'(rs1) + int'(rs2);
      OP_MUL:  v = int'(rs1) * int'(rs2);
      default: v = 0;
    endcase
    r.rd    = v % 16;
    r.taken = (rs2 == 4'd0) ? 1 : 0;
    np      = (is_br && rs2 == 4'd0) ? int'(pc) + int'(off) : int'(pc) + 1;
    r.npc   = np % 16;
    r.tag   = int'(tag);
    return r;
  endfunction

  // Transaction model: one op in flight, latency by kind, drain after a flushed load.
  bit   m_busy, m_valid, m_drain, m_phase;
  int   m_kind, m_count, m_addr;
  res_t m_res;

  initial begin
    m_busy = 0; m_valid = 0; m_drain = 0; m_phase = 0; m_kind = 0; m_count = 0; m_addr = 0;
    forever begin
      @(negedge clk);
      if (rst) begin m_busy = 0; m_valid = 0; m_drain = 0; end
      chk("m_in_ready", bus.in_ready, (!m_busy && !m_drain && !bus.flush && !rst) ? 1 : 0);
      chk("m_out_valid", bus.out_valid, m_valid ? 1 : 0);
      chk("m_mem_req_valid", bus.mem_req_valid, (m_busy && m_kind == 2 && !m_phase) ? 1 : 0);
      if (m_busy && m_kind == 2 && !m_phase) chk("m_mem_req_addr", bus.mem_req_addr, m_addr);
      if (m_valid) begin
        chk("m_rd", bus.out_rd_data, m_res.rd);
        chk("m_taken", bus.out_taken, m_res.taken);
        chk("m_next_pc", bus.out_next_pc, m_res.npc);
        chk("m_tag", bus.out_tag, m_res.tag);
      end
      if (rst) begin
      end else if (bus.flush) begin
        m_drain = m_busy && m_kind == 2 && m_phase && !m_valid && !bus.mem_resp_valid;
        m_busy = 0; m_valid = 0;
      end else if (m_drain) begin
        if (bus.mem_resp_valid) m_drain = 0;
      end else if (!m_busy) begin
        if (bus.in_valid) begin
          m_busy = 1; m_phase = 0;
          m_res = model_op(bus.in_op, bus.in_imm, bus.in_rs1_data, bus.in_rs2_data,
                           bus.in_pc, bus.in_br_offset, bus.in_is_br, bus.in_tag);
          m_addr = int'(bus.in_rs1_data) % 4;
          if (!bus.in_use_alu) m_kind = 2;
          else if (bus.in_op == OP_MUL) begin m_kind = 1; m_count = REG_LEN; end
          else begin m_kind = 0; m_valid = 1; end
        end
      end else if (m_valid) begin
        if (bus.out_ready) begin m_busy = 0; m_valid = 0; end
      end else if (m_kind == 1) begin
        m_count--;
        if (m_count == 0) m_valid = 1;
      end else if (m_kind == 2) begin
        if (!m_phase) begin
          if (bus.mem_req_ready) m_phase = 1;
        end else if (bus.mem_resp_valid) begin
          m_res.rd = int'(bus.mem_resp_data);
          m_valid = 1;
        end
      end
    end
  end

  task automatic drive(input vec_t v, input logic use_alu);
    bus.in_op = v.op; bus.in_imm = v.imm; bus.in_rs1_data = v.rs1; bus.in_rs2_data = v.rs2;
    bus.in_pc = v.pc; bus.in_br_offset = v.off; bus.in_is_br = v.is_br; bus.in_tag = v.tag;
    bus.in_use_alu = use_alu;
  endtask

  // Returns #1 after the accepting edge.
  task automatic issue(input vec_t v, input logic use_alu);
    bit ok;
    ok = 0;
    @(posedge clk); #1;
    drive(v, use_alu);
    bus.in_valid = 1'b1;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (bus.in_ready) begin @(posedge clk); #1; ok = 1; end
    end
    bus.in_valid = 1'b0;
    chk("accept", ok ? 1 : 0, 1);
  endtask

  task automatic wait_out(output int lat);
    bit seen;
    seen = 0; lat = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      lat++;
      if (bus.out_valid) seen = 1;
    end
    chk("out_valid_seen", seen ? 1 : 0, 1);
  endtask

  task automatic run_vec(input int idx);
    int lat;
    vec_t v;
    v = vecs[idx];
    issue(v, 1'b1);
    wait_out(lat);
    chk($sformatf("v%0d_lat", idx), lat, v.lat);
    chk($sformatf("v%0d_rd", idx), bus.out_rd_data, v.rd);
    chk($sformatf("v%0d_taken", idx), bus.out_taken, v.taken);
    chk($sformatf("v%0d_next_pc", idx), bus.out_next_pc, v.npc);
    chk($sformatf("v%0d_tag", idx), bus.out_tag, int'(v.tag));
    @(negedge clk);
    chk($sformatf("v%0d_ready_after", idx), bus.in_ready, 1);
  endtask

  // Load rs1=6 (addr 2), pc=5, tag=3; returns #1 after the request handshake edge.
  task automatic load_handshake();
    vec_t lv;
    lv = '{OP_LI, 4'd0, 4'd6, 4'd2, 4'd5, 4'd0, 1'b0, 2'd3, 0, 0, 6, 0};
    issue(lv, 1'b0);
    bus.mem_req_ready = 1'b1;
    @(posedge clk); #1;
    bus.mem_req_ready = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    vec_t lv;
    vecs[0] = '{OP_ADD, 4'd0, 4'd7,  4'd12, 4'd3,  4'd0, 1'b0, 2'd2, 3,  0, 4,  1};
    vecs[1] = '{OP_LI,  4'd9, 4'd0,  4'd0,  4'd15, 4'd0, 1'b0, 2'd1, 9,  1, 0,  1};
    vecs[2] = '{OP_UND, 4'd0, 4'd5,  4'd5,  4'd2,  4'd0, 1'b0, 2'd0, 0,  0, 3,  1};
    vecs[3] = '{OP_ADD, 4'd0, 4'd1,  4'd0,  4'd14, 4'd5, 1'b1, 2'd3, 1,  1, 3,  1};
    vecs[4] = '{OP_LI,  4'd4, 4'd0,  4'd1,  4'd14, 4'd5, 1'b1, 2'd0, 4,  0, 15, 1};
    vecs[5] = '{OP_MUL, 4'd0, 4'd5,  4'd6,  4'd0,  4'd0, 1'b0, 2'd1, 14, 0, 1,  5};
    vecs[6] = '{OP_MUL, 4'd0, 4'd15, 4'd15, 4'd7,  4'd0, 1'b0, 2'd2, 1,  0, 8,  5};
    vecs[7] = '{OP_MUL, 4'd0, 4'd3,  4'd0,  4'd8,  4'd4, 1'b1, 2'd3, 0,  1, 12, 5};

    bus.flush = 0; bus.in_valid = 0; drive(vecs[0], 1'b1);
    bus.mem_req_ready = 0; bus.mem_resp_valid = 0; bus.mem_resp_data = 0; bus.out_ready = 1;
    #1 rst = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_mem_req_valid", bus.mem_req_valid, 0);
    chk("rst_rd", bus.out_rd_data, 0);
    chk("rst_taken", bus.out_taken, 0);
    chk("rst_next_pc", bus.out_next_pc, 0);
    chk("rst_tag", bus.out_tag, 0);
    chk("rst_addr", bus.mem_req_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("idle_ready", bus.in_ready, 1);

    for (int i = 0; i < 8; i++) run_vec(i);

    // load with a stalled request channel
    lv = '{OP_LI, 4'd0, 4'd6, 4'd2, 4'd5, 4'd0, 1'b0, 2'd3, 0, 0, 6, 0};
    issue(lv, 1'b0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("ld_req_valid", bus.mem_req_valid, 1);
      chk("ld_req_addr", bus.mem_req_addr, 2);
    end
    @(posedge clk); #1 bus.mem_req_ready = 1'b1;
    @(posedge clk); #1 bus.mem_req_ready = 1'b0;
    @(posedge clk); #1 bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 4'd9;
    @(negedge clk);
    chk("ld_wait_no_out", bus.out_valid, 0);
    @(posedge clk); #1 bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("ld_out_valid", bus.out_valid, 1);
    chk("ld_rd", bus.out_rd_data, 9);
    chk("ld_tag", bus.out_tag, 3);
    chk("ld_next_pc", bus.out_next_pc, 6);
    @(negedge clk);
    chk("ld_ready_after", bus.in_ready, 1);

    // flush in MEM_WAIT, late response drained
    load_handshake();
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("drain_ready0", bus.in_ready, 0);
    @(posedge clk); #1 bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 4'd7;
    @(negedge clk);
    chk("drain_ready1", bus.in_ready, 0);
    @(posedge clk); #1 bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("drain_ready2", bus.in_ready, 1);
    chk("drain_no_out", bus.out_valid, 0);

    // flush coinciding with the response in MEM_WAIT
    load_handshake();
    bus.flush = 1'b1; bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 4'd5;
    @(posedge clk); #1 bus.flush = 1'b0; bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("coinc_ready", bus.in_ready, 1);
    chk("coinc_no_out", bus.out_valid, 0);

    // reset during MEM_WAIT
    load_handshake();
    rst = 1'b1;
    #2;
    chk("rstw_in_ready", bus.in_ready, 0);
    chk("rstw_req_valid", bus.mem_req_valid, 0);
    chk("rstw_out_valid", bus.out_valid, 0);
    chk("rstw_next_pc", bus.out_next_pc, 0);
    chk("rstw_tag", bus.out_tag, 0);
    chk("rstw_addr", bus.mem_req_addr, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    chk("rstw_ready", bus.in_ready, 1);
    @(posedge clk); #1 bus.mem_resp_valid = 1'b1; bus.mem_resp_data = 4'd9;
    @(negedge clk);
    chk("rstw_late_ready", bus.in_ready, 1);
    @(posedge clk); #1 bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("rstw_no_out", bus.out_valid, 0);
    chk("rstw_rd", bus.out_rd_data, 0);

    // result held in DONE while out_ready is low, new op not accepted
    bus.out_ready = 1'b0;
    lv = '{OP_ADD, 4'd0, 4'd2, 4'd3, 4'd6, 4'd0, 1'b0, 2'd1, 5, 0, 7, 1};
    issue(lv, 1'b1);
    wait_out(lat);
    chk("stall_lat", lat, 1);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      drive(vecs[1], 1'b1);
      bus.in_valid = 1'b1;
      @(negedge clk);
      chk("stall_in_ready", bus.in_ready, 0);
      chk("stall_out_valid", bus.out_valid, 1);
      chk("stall_rd", bus.out_rd_data, 5);
      chk("stall_tag", bus.out_tag, 1);
      chk("stall_next_pc", bus.out_next_pc, 7);
    end
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("stall_consumed_valid", bus.out_valid, 1);
    @(negedge clk);
    chk("stall_release", bus.in_ready, 1);
    chk("stall_gone", bus.out_valid, 0);

    // flush during MUL
    issue(vecs[5], 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("fmul_ready", bus.in_ready, 1);
    repeat (6) @(negedge clk);
    chk("fmul_no_out", bus.out_valid, 0);

    // flush during MEM_REQ
    issue(lv, 1'b0);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("freq_req_valid", bus.mem_req_valid, 0);
    chk("freq_ready", bus.in_ready, 1);

    // flush in DONE together with out_ready
    issue(vecs[0], 1'b1);
    bus.flush = 1'b1;
    @(negedge clk);
    chk("fdone_valid", bus.out_valid, 1);
    chk("fdone_rd", bus.out_rd_data, 3);
    @(posedge clk); #1 bus.flush = 1'b0;
    @(negedge clk);
    chk("fdone_ready", bus.in_ready, 1);
    chk("fdone_gone", bus.out_valid, 0);

    // flush in DONE without out_ready
    bus.out_ready = 1'b0;
    issue(vecs[1], 1'b1);
    bus.flush = 1'b1;
    @(posedge clk); #1 bus.flush = 1'b0; bus.out_ready = 1'b1;
    @(negedge clk);
    chk("fhold_gone", bus.out_valid, 0);
    chk("fhold_ready", bus.in_ready, 1);

    // flush while offering in IDLE blocks the accept
    @(posedge clk); #1;
    drive(vecs[0], 1'b1);
    bus.in_valid = 1'b1; bus.flush = 1'b1;
    @(negedge clk);
    chk("fidle_ready", bus.in_ready, 0);
    @(posedge clk); #1 bus.in_valid = 1'b0; bus.flush = 1'b0;
    @(negedge clk);
    chk("fidle_no_out", bus.out_valid, 0);
    chk("fidle_ready_after", bus.in_ready, 1);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/exec_unit_mc.md
EXEC_UNIT_MC -- requirements
Module: exec_unit_mc

Interface
REQ-001 Parameters SHALL be:
  REG_LEN        4  data width
  MEMI_SIZE_LOG  4  PC width
  MEMD_SIZE_LOG  2  data-memory address width
  INST_SIZE_LOG  2  op width
  TAG_W          2  tag width
REQ-002 Ports SHALL be:
  clk            in   1              clock
  rst            in   1              asynchronous active-high reset
  flush          in   1              kill in-flight op
  in_valid       in   1              op offered
  in_ready       out  1              op accepted when in_valid&in_ready
  in_pc          in   MEMI_SIZE_LOG  op PC
  in_op          in   INST_SIZE_LOG  `INST_OP_LI/ADD/MUL encoding
  in_imm         in   REG_LEN        LI immediate
  in_br_offset   in   MEMI_SIZE_LOG  branch offset
  in_rs1_data    in   REG_LEN        source 1 / load address
  in_rs2_data    in   REG_LEN        source 2 / branch condition
  in_use_alu     in   1              1=ALU result, 0=load
  in_is_br       in   1              op is branch
  in_tag         in   TAG_W          opaque tag
  mem_req_valid  out  1              load request
  mem_req_ready  in   1              request accepted
  mem_req_addr   out  MEMD_SIZE_LOG  load address
  mem_resp_valid in   1              load data valid
  mem_resp_data  in   REG_LEN        load data
  out_valid      out  1              result valid
  out_ready      in   1              result consumed
  out_rd_data    out  REG_LEN        destination value
  out_taken      out  1              branch taken
  out_next_pc    out  MEMI_SIZE_LOG  next PC
  out_tag        out  TAG_W          tag of result

Function
REQ-003 FSM states SHALL be IDLE, MUL, MEM_REQ, MEM_WAIT, DRAIN, DONE.
REQ-004 in_ready SHALL equal (state==IDLE)&~flush&~rst.
REQ-005 On accept, all in_* fields SHALL be registered; the next state SHALL be MEM_REQ if ~in_use_alu, MUL if in_use_alu&op==MUL, else DONE.
REQ-006 LI SHALL yield in_imm; ADD SHALL yield (rs1+rs2) mod 2^REG_LEN; undefined op SHALL yield 0.
REQ-007 MUL SHALL be iterative shift-add, one multiplier bit per cycle, exactly REG_LEN cycles in MUL, result (rs1*rs2) mod 2^REG_LEN, then DONE.
REQ-008 out_taken SHALL equal (rs2==0); out_next_pc SHALL equal pc+br_offset if is_br&taken else pc+1, mod 2^MEMI_SIZE_LOG; out_taken SHALL be computed for non-branches but ignored by consumers.
REQ-009 In MEM_REQ, mem_req_valid=1, mem_req_addr=rs1[MEMD_SIZE_LOG-1:0]; on mem_req_ready go to MEM_WAIT.
REQ-010 mem_resp_valid SHALL be sampled only in MEM_WAIT or DRAIN; in MEM_WAIT it captures mem_resp_data as rd and goes to DONE.
REQ-011 In DONE, out_valid=1 with all out_* stable until out_ready; on out_ready go to IDLE.
REQ-012 Latency: LI/ADD/branch out_valid 1 cycle after accept; MUL REG_LEN+1 cycles; load 1 cycle after mem_resp_valid.
REQ-013 flush SHALL override all else: from MEM_WAIT go to DRAIN; from any other state go to IDLE; out_valid and mem_req_valid SHALL be 0 in the flush cycle's next state.
REQ-014 DRAIN SHALL discard one mem_resp_valid, then go to IDLE; a response coinciding with flush in MEM_WAIT SHALL count as drained (go to IDLE).
REQ-015 flush with out_valid&out_ready in the same cycle: result SHALL count as consumed.

Reset
REQ-016 rst SHALL asynchronously force IDLE, multiplier counter 0, all registered operands 0, out_valid=0, mem_req_valid=0, out_rd_data/out_taken/out_next_pc/out_tag=0, mem_req_addr=0.
REQ-017 rst mid-operation (any state, including MEM_WAIT) SHALL abandon the op; no drain after reset.

Verification
REQ-018 ADD rs1=7, rs2=12, tag=2, out_ready=1 -> out_valid next cycle, rd=3, tag=2, next_pc=pc+1, then in_ready=1.
REQ-019 MUL rs1=5, rs2=6 -> in_ready=0 for 5 cycles, out_valid 5 cycles after accept, rd=14.
REQ-020 Branch pc=14, offset=5, rs2=0 -> taken=1, next_pc=3; rs2=1 -> taken=0, next_pc=15.
REQ-021 Load rs1=6, mem_req_ready held low 3 cycles, response data=9 two cycles after handshake -> mem_req_addr=2 held stable, rd=9, out_valid one cycle after response.
REQ-022 Load flushed in MEM_WAIT, response 2 cycles later -> no out_valid, in_ready=0 until response, then 1; same with rst mid-MEM_WAIT -> IDLE immediately, late response ignored.
REQ-023 DONE with out_ready low 4 cycles -> out_* stable, in_ready=0 throughout, new in_valid not accepted.
